prog_mux_bank: RTL and testbench
================================

Name: prog_mux_bank

Overview:
Multi-channel programmable routing mux, configured serially over the config scan chain. CHANNELS independent output muxes, each selecting one of INPUTS data lines. Serial config is shifted into a shadow chain and transferred to the active select registers only on an explicit commit, so routing never glitches mid-programming. Sits in the routing fabric, daisy-chained with other config elements through config_in/config_out.

Parameters:
SEL, 4, select bits per channel
INPUTS, 16, data inputs per mux (must be <= 2**SEL)
CHANNELS, 4, number of independent output muxes
W (localparam), SEL*CHANNELS, shadow/active chain length
CNT_W (localparam), clog2(W+1), bit-counter width

Ports:
config_clk  input  1  sole clock, rising edge
sys_reset  input  1  asynchronous, active-high reset
config_in  input  1  serial config data
config_en  input  1  shift enable
config_commit  input  1  transfer shadow -> active (single-cycle pulse)
config_out  output  1  serial chain output = shadow[W-1]
data_in  input  INPUTS  shared data inputs
data_out  output  CHANNELS  routed outputs, bit c = channel c
config_done  output  1  one-cycle pulse after a successful commit
config_err  output  1  sticky error flag
bit_count  output  CNT_W  bits shifted since last commit, saturating at W

Behaviour:
- Reset (async assert, sync-safe deassert by design): shadow=0, active=0, bit_count=0, state=IDLE, config_done=0, config_err=0. data_out[c]=data_in[0] for all c.
- Shift: at rising edge with config_en=1, shadow <= {shadow[W-2:0], config_in}. config_out is combinational from shadow[W-1], so a chain of N bits delays by exactly W cycles.
- Mapping: channel c select = active[c*SEL +: SEL]. The first bit shifted in ends at shadow[W-1] (MSB of channel CHANNELS-1). Frames are sent MSB-first, highest channel first.
- bit_count increments on each shift and saturates at W. Over-shifting is legal (daisy-chain pass-through); the last W bits shifted win.
- FSM, encoded from bit_count:
  - IDLE: count=0.
  - LOADING: 0<count<W.
  - FULL: count=W.
  - Shift moves IDLE->LOADING->FULL. Successful commit moves FULL->IDLE.
- Commit is sampled at the rising edge and valid only when config_en=0:
  - In FULL: active <= shadow, bit_count <= 0, config_err <= 0, config_done=1 for exactly the next cycle.
  - In IDLE/LOADING: active unchanged, bit_count unchanged, config_err <= 1, no done pulse.
  - Commit with config_en=1: shift performed, commit ignored, config_err <= 1.
- data_out is combinational from active and data_in (zero latency from data_in; one edge after commit for a select change). Shadow contents never affect data_out.
- Out-of-range select (value >= INPUTS): that channel drives 0.
- config_err clears only on reset or a successful commit.
- Reset mid-shift: partial shadow is discarded and active returns to 0. Reset overrides a simultaneous commit.

Test Plan:
- Defaults (SEL=4, INPUTS=16, CHANNELS=4): reset, data_in=16'h0001 -> data_out=4'b1111, bit_count=0, config_done=0, config_err=0.
- Shift 16'h3A5C MSB-first, hold data_in=16'h1400 -> data_out stays 4'b0000 during shifting. Commit -> next cycle data_out=4'b0101 (ch0 sel 12, ch2 sel 10), config_done high exactly one cycle, bit_count=0.
- Shift 10 bits, commit -> config_err=1, active unchanged, no done pulse, bit_count=10. Then 6 more bits plus commit -> err=0, done=1.
- Shift 20 bits 1,0,1,1 followed by 16'h0000 -> config_out emits 1,0,1,1 on shifts 17-20, bit_count saturates at 16. Commit loads all zeros.
- config_en=1 and config_commit=1 together in FULL -> shift occurs, active unchanged, config_err=1.
- INPUTS=12 build: commit with ch1 select=13 -> data_out[1]=0 for any data_in. Reset asserted mid-shift after 7 bits -> all outputs back to reset values within the same cycle (asynchronous).

Source files
------------

// File: rtl/prog_mux_bank.sv
// Serially configured multi-channel routing mux. A shadow scan chain is loaded bit by bit
// and copied into the active select registers only on a commit while the chain is full.
module prog_mux_bank #(
    parameter  int SEL      = 4,
    parameter  int INPUTS   = 16,
    parameter  int CHANNELS = 4,
    localparam int W        = SEL * CHANNELS,
    localparam int CNT_W    = $clog2(W + 1)
) (
    input  logic                config_clk,
    input  logic                sys_reset,
    input  logic                config_in,
    input  logic                config_en,
    input  logic                config_commit,
    output logic                config_out,
    input  logic [INPUTS-1:0]   data_in,
    output logic [CHANNELS-1:0] data_out,
    output logic                config_done,
    output logic                config_err,
    output logic [CNT_W-1:0]    bit_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t         state_r;
    logic [W-1:0]   shadow_r;
    logic [W-1:0]   active_r;

    // Select values at or above INPUTS have no data line behind them and route a constant 0.
    function automatic logic route_bit(input logic [SEL-1:0] sel, input logic [INPUTS-1:0] din);
        logic bit_v;
        bit_v = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
            bit_v = bit_v | ((int'(sel) == i) & din[i]);
        end
        return bit_v;
    endfunction

    assign config_out = shadow_r[W-1];

    // Shift/commit controller; state tracks the saturating bit count.
    always_ff @(posedge config_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_r     <= IDLE;
            shadow_r    <= {W{1'b0}};
            active_r    <= {W{1'b0}};
            bit_count   <= {CNT_W{1'b0}};
            config_done <= 1'b0;
            config_err  <= 1'b0;
        end else begin
            config_done <= 1'b0;
            if (config_en) begin
                shadow_r <= {shadow_r[W-2:0], config_in};
                if (state_r != FULL) begin
                    bit_count <= bit_count + CNT_W'(1);
                    state_r   <= (bit_count == CNT_W'(W - 1)) ? FULL : LOADING;
                end else begin
                    bit_count <= bit_count;
                    state_r   <= FULL;
                end
                // A commit during a shift is dropped but still flagged.
                if (config_commit) begin
                    config_err <= 1'b1;
                end else begin
                    config_err <= config_err;
                end
            end else if (config_commit) begin
                case (state_r)
                    FULL: begin
                        active_r    <= shadow_r;
                        bit_count   <= {CNT_W{1'b0}};
                        state_r     <= IDLE;
                        config_err  <= 1'b0;
                        config_done <= 1'b1;
                    end
                    default: begin
                        config_err <= 1'b1;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Per-channel output mux, driven only by the active selects.
    always_comb begin
        data_out = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            data_out[c] = route_bit(active_r[c*SEL +: SEL], data_in);
        end
    end

endmodule

// File: tb/tb_prog_mux_bank.sv
// Directed bench for prog_mux_bank: default build plus an INPUTS=12 build sharing stimulus.
module tb_prog_mux_bank;

    logic        config_clk = 1'b0;
    logic        sys_reset;
    logic        config_in;
    logic        config_en;
    logic        config_commit;
    logic [15:0] data_in;

    logic        config_out;
    logic [3:0]  data_out;
    logic        config_done;
    logic        config_err;
    logic [4:0]  bit_count;

    logic        b_config_out;
    logic [3:0]  b_data_out;
    logic        b_config_done;
    logic        b_config_err;
    logic [4:0]  b_bit_count;

    int checks   = 0;
    int failures = 0;

    prog_mux_bank dut (
        .config_clk   (config_clk),
        .sys_reset    (sys_reset),
        .config_in    (config_in),
        .config_en    (config_en),
        .config_commit(config_commit),
        .config_out   (config_out),
        .data_in      (data_in),
        .data_out     (data_out),
        .config_done  (config_done),
        .config_err   (config_err),
        .bit_count    (bit_count)
    );

    prog_mux_bank #(.INPUTS(12)) dut12 (
        .config_clk   (config_clk),
        .sys_reset    (sys_reset),
        .config_in    (config_in),
        .config_en    (config_en),
        .config_commit(config_commit),
        .config_out   (b_config_out),
        .data_in      (data_in[11:0]),
        .data_out     (b_data_out),
        .config_done  (b_config_done),
        .config_err   (b_config_err),
        .bit_count    (b_bit_count)
    );

    always #5 config_clk = ~config_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge config_clk);
        #1;
    endtask

    task automatic shift_bits(input logic [31:0] value, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            config_en = 1'b1;
            config_in = value[i];
            tick();
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    task automatic commit();
        config_commit = 1'b1;
        tick();
        config_commit = 1'b0;
    endtask

    initial begin
        logic [3:0] seq;
        seq           = 4'b1011;
        sys_reset     = 1'b1;
        config_in     = 1'b0;
        config_en     = 1'b0;
        config_commit = 1'b0;
        data_in       = 16'h0001;
        #12;
        check("rst_data_out", 32'(data_out), 32'h0000000F);
        check("rst_bit_count", 32'(bit_count), 32'd0);
        check("rst_done", 32'(config_done), 32'd0);
        check("rst_err", 32'(config_err), 32'd0);
        check("rst_config_out", 32'(config_out), 32'd0);
        sys_reset = 1'b0;

        // Full frame 3A5C: ch0 sel 12, ch2 sel 10.
        data_in = 16'h1400;
        shift_bits(32'h3A, 8);
        check("shift_mid_data_out", 32'(data_out), 32'h0);
        check("shift_mid_count", 32'(bit_count), 32'd8);
        shift_bits(32'h5C, 8);
        check("shift_full_count", 32'(bit_count), 32'd16);
        check("shift_full_data_out", 32'(data_out), 32'h0);
        commit();
        check("commit_data_out", 32'(data_out), 32'h5);
        check("commit_done", 32'(config_done), 32'd1);
        check("commit_count", 32'(bit_count), 32'd0);
        check("commit_err", 32'(config_err), 32'd0);
        tick();
        check("done_one_cycle", 32'(config_done), 32'd0);

        // Premature commit after 10 bits of frame 0F03, then finish the frame.
        data_in = 16'h8001;
        shift_bits(32'h0F03 >> 6, 10);
        commit();
        check("early_err", 32'(config_err), 32'd1);
        check("early_done", 32'(config_done), 32'd0);
        check("early_count", 32'(bit_count), 32'd10);
        check("early_data_out", 32'(data_out), 32'h0);
        shift_bits(32'h0F03, 6);
        commit();
        check("late_done", 32'(config_done), 32'd1);
        check("late_err", 32'(config_err), 32'd0);
        check("late_data_out", 32'(data_out), 32'hE);

        // Over-shift 20 bits: 1,0,1,1 then sixteen zeros.
        data_in = 16'h0001;
        shift_bits(32'hB000, 16);
        check("pass_out_16", 32'(config_out), 32'(seq[3]));
        for (int j = 0; j < 3; j++) begin
            shift_bits(32'h0, 1);
            check("pass_out_seq", 32'(config_out), 32'(seq[2-j]));
        end
        shift_bits(32'h0, 1);
        check("sat_count", 32'(bit_count), 32'd16);
        check("pre_zero_data_out", 32'(data_out), 32'hA);
        commit();
        check("zero_data_out", 32'(data_out), 32'hF);
        check("zero_done", 32'(config_done), 32'd1);

        // Shift and commit together while full: shift wins, commit flagged.
        shift_bits(32'h3A5C, 16);
        config_en     = 1'b1;
        config_in     = 1'b0;
        config_commit = 1'b1;
        tick();
        config_en     = 1'b0;
        config_commit = 1'b0;
        check("both_err", 32'(config_err), 32'd1);
        check("both_done", 32'(config_done), 32'd0);
        check("both_count", 32'(bit_count), 32'd16);
        check("both_data_out", 32'(data_out), 32'hF);
        commit();
        data_in = 16'h0100;
        #1;
        check("both_shifted_frame", 32'(data_out), 32'h1);
        check("both_recover_err", 32'(config_err), 32'd0);

        // ch1 sel 13: out of range only for the 12-input build.
        shift_bits(32'h00D0, 16);
        commit();
        data_in = 16'hFFFF;
        #1;
        check("oor16_ones", 32'(data_out), 32'hF);
        check("oor12_ones", 32'(b_data_out), 32'hD);
        data_in = 16'h2000;
        #1;
        check("oor16_bit13", 32'(data_out), 32'h2);
        check("oor12_bit13", 32'(b_data_out), 32'h0);

        // Asynchronous reset mid-shift with a sticky error pending.
        data_in = 16'h0001;
        shift_bits(32'h55, 7);
        commit();
        check("pre_rst_err", 32'(config_err), 32'd1);
        check("pre_rst_count", 32'(bit_count), 32'd7);
        check("pre_rst_data_out", 32'(data_out), 32'hD);
        #2;
        sys_reset = 1'b1;
        #1;
        check("arst_count", 32'(bit_count), 32'd0);
        check("arst_err", 32'(config_err), 32'd0);
        check("arst_data_out", 32'(data_out), 32'hF);
        check("arst_data_out12", 32'(b_data_out), 32'hF);
        check("arst_config_out", 32'(config_out), 32'd0);
        @(negedge config_clk);
        sys_reset = 1'b0;
        tick();
        check("post_rst_count", 32'(bit_count), 32'd0);
        check("post_rst_count12", 32'(b_bit_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
